lenet_image_feeder: RTL and testbench

Sequencer that streams a batch of 28×28 input images from the input ROM into the LeNet core, one 16-bit pixel per cycle. It steps the ROM address through each image, waits for the core's `layer1_finish` before moving to the next image base, and collects each classification from `finish`/`index`. It replaces free-running address logic with a start/done controlled block that sits between `input_rom` and `LeNet`.

---
 rtl/lenet_image_feeder_if.sv | 24 ++
 rtl/lenet_image_feeder.sv | 150 +++++++++++++++
 tb/tb_lenet_image_feeder.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lenet_image_feeder_if.sv
// Feeder <-> input ROM / LeNet core signal bundle.
// master = feeder side, slave = ROM/core side.
interface lenet_image_feeder_if #(
  parameter int unsigned ADDR_W = 14
);
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic [15:0]       map_out;
  logic              map_valid;
  logic              lenet_en;
  logic              layer1_finish;
  logic              finish;
  logic [3:0]        index;

  modport master (
    output rom_addr, map_out, map_valid, lenet_en,
    input  rom_data, layer1_finish, finish, index
  );

  modport slave (
    input  rom_addr, map_out, map_valid, lenet_en,
    output rom_data, layer1_finish, finish, index
  );
endinterface

// File: rtl/lenet_image_feeder.sv
// Streams a batch of images from the input ROM into the LeNet core and collects results.
// Optional batch cycle counter enabled by defining LENET_FEEDER_PERF_EN.
module lenet_image_feeder #(
  parameter int unsigned IMG_PIXELS = 784,
  parameter int unsigned NUM_IMAGES = 10,
  parameter int unsigned ADDR_W     = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  lenet_image_feeder_if.master bus,
  output logic                result_valid,
  output logic [3:0]          result_index,
  output logic [ADDR_W-1:0]   result_img,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [31:0]         perf_cycles
);

  localparam int unsigned PIX_W = $clog2(IMG_PIXELS + 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(IMG_PIXELS - 1);
  localparam logic [ADDR_W-1:0] IMG_STEP  = ADDR_W'(IMG_PIXELS);
  localparam logic [ADDR_W-1:0] IMG_LAST  = ADDR_W'(NUM_IMAGES - 1);
  localparam logic [ADDR_W-1:0] IMG_TOTAL = ADDR_W'(NUM_IMAGES);

  typedef enum logic [2:0] {S_IDLE, S_STREAM, S_WAIT_L1, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] next_base;
  logic [ADDR_W-1:0] img_cnt;
  logic [ADDR_W-1:0] res_cnt;
  logic [PIX_W-1:0]  pix_cnt;
  logic              map_valid_q;
  logic              lenet_en_q;

  assign next_base     = base + IMG_STEP;
  assign bus.rom_addr  = addr;
  assign bus.map_out   = bus.rom_data;
  assign bus.map_valid = map_valid_q;
  assign bus.lenet_en  = lenet_en_q;

  // Sequencer FSM plus result capture; ROM data lags its address by one cycle, so map_valid does too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      addr         <= '0;
      base         <= '0;
      img_cnt      <= '0;
      res_cnt      <= '0;
      pix_cnt      <= '0;
      map_valid_q  <= 1'b0;
      lenet_en_q   <= 1'b0;
      result_valid <= 1'b0;
      result_index <= '0;
      result_img   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      done         <= 1'b0;
      map_valid_q  <= (state == S_STREAM);
      if (state == S_STREAM) lenet_en_q <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            base    <= '0;
            addr    <= '0;
            pix_cnt <= '0;
            img_cnt <= '0;
            res_cnt <= '0;
            err     <= 1'b0;
            busy    <= 1'b1;
            state   <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (bus.layer1_finish) err <= 1'b1;
          if (pix_cnt == PIX_LAST) begin
            state <= S_WAIT_L1;
          end else begin
            addr    <= addr + ADDR_W'(1);
            pix_cnt <= pix_cnt + PIX_W'(1);
          end
        end
        S_WAIT_L1: begin
          if (bus.layer1_finish) begin
            if (img_cnt == IMG_LAST) begin
              state <= S_DRAIN;
            end else begin
              base    <= next_base;
              addr    <= next_base;
              pix_cnt <= '0;
              img_cnt <= img_cnt + ADDR_W'(1);
              state   <= S_STREAM;
            end
          end
        end
        S_DRAIN: begin
          if (res_cnt == IMG_TOTAL) begin
            done       <= 1'b1;
            lenet_en_q <= 1'b0;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Results may arrive while later images stream; extras and idle ones only flag err.
      if (bus.finish) begin
        if (state == S_IDLE || res_cnt == IMG_TOTAL) begin
          err <= 1'b1;
        end else begin
          result_valid <= 1'b1;
          result_index <= bus.index;
          result_img   <= res_cnt;
          res_cnt      <= res_cnt + ADDR_W'(1);
        end
      end
    end
  end

`ifdef LENET_FEEDER_PERF_EN
  logic [31:0] perf_q;

  // Counts every busy cycle including DONE, then holds until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (state == S_IDLE) begin
      if (start) perf_q <= '0;
    end else begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_lenet_image_feeder.sv
// Self-checking bench for lenet_image_feeder with a random-content ROM and a queue-based stream model.
module tb_lenet_image_feeder;
  localparam int IMG   = 784;
  localparam int NIMG  = 2;
  localparam int AW    = 14;
  localparam int TOTAL = IMG * NIMG;
  localparam int BOUND = 4000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          result_valid;
  logic [3:0]    result_index;
  logic [AW-1:0] result_img;
  logic          busy, done, err;
  logic [31:0]   perf_cycles;

  lenet_image_feeder_if #(.ADDR_W(AW)) bus();

  lenet_image_feeder #(.IMG_PIXELS(IMG), .NUM_IMAGES(NIMG), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .result_valid(result_valid), .result_index(result_index), .result_img(result_img),
    .busy(busy), .done(done), .err(err), .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  logic [15:0] rom_mem [TOTAL];
  always @(posedge clk)
    bus.rom_data <= (int'(bus.rom_addr) < TOTAL) ? rom_mem[int'(bus.rom_addr)] : 16'h0;

  int errors = 0;
  int checks = 0;

  // Observation queues filled every falling edge
  int          cyc = 0;
  int          busy_cnt;
  int          run_len;
  int          first_mv, first_en;
  logic [15:0] pix_q[$];
  int          run_q[$];
  int          addr_q[$];
  int          res_img_q[$], res_idx_q[$], res_cyc_q[$], done_cyc_q[$];

  always @(negedge clk) begin
    cyc++;
    if (busy === 1'b1) begin
      busy_cnt++;
      if (addr_q.size() == 0 || addr_q[$] != int'(bus.rom_addr)) addr_q.push_back(int'(bus.rom_addr));
    end
    if (bus.map_valid === 1'b1) begin
      pix_q.push_back(bus.map_out);
      run_len++;
      if (first_mv < 0) first_mv = cyc;
    end else if (run_len > 0) begin
      run_q.push_back(run_len);
      run_len = 0;
    end
    if (bus.lenet_en === 1'b1 && first_en < 0) first_en = cyc;
    if (result_valid === 1'b1) begin
      res_img_q.push_back(int'(result_img));
      res_idx_q.push_back(int'(result_index));
      res_cyc_q.push_back(cyc);
    end
    if (done === 1'b1) done_cyc_q.push_back(cyc);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_mon();
    busy_cnt = 0; run_len = 0; first_mv = -1; first_en = -1;
    pix_q.delete(); run_q.delete(); addr_q.delete();
    res_img_q.delete(); res_idx_q.delete(); res_cyc_q.delete(); done_cyc_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_l1();
    bus.layer1_finish = 1'b1; tick(); bus.layer1_finish = 1'b0;
  endtask

  task automatic pulse_finish(input logic [3:0] idx);
    bus.finish = 1'b1; bus.index = idx; tick(); bus.finish = 1'b0;
  endtask

  task automatic wait_addr(input int target);
    int n = 0;
    while (!(busy === 1'b1 && int'(bus.rom_addr) == target) && n < BOUND) begin
      tick(); n++;
    end
    checks++;
    if (n >= BOUND) begin
      errors++;
      $display("FAIL wait_addr_%0d: got timeout after %0d cycles, want address reached", target, n);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < BOUND) begin
      tick(); n++;
    end
    checks++;
    if (n >= BOUND) begin
      errors++;
      $display("FAIL wait_done: got timeout after %0d cycles, want done pulse", n);
    end
  endtask

  // Whole batch from just after start: img0 result during img1 streaming, img1 result in drain.
  task automatic drive_batch(input int d0, input int d1, input logic [3:0] i0, input logic [3:0] i1);
    wait_addr(IMG - 1);
    repeat (d0) tick();
    pulse_l1();
    wait_addr(IMG + 200);
    pulse_finish(i0);
    wait_addr(TOTAL - 1);
    repeat (d1) tick();
    pulse_l1();
    repeat (2) tick();
    pulse_finish(i1);
    wait_done();
  endtask

  // Compares the observed stream against the ROM image: contiguous addresses, pixels in order, one run per image.
  task automatic check_stream(input string tag);
    int good_p = 0;
    int good_a = 0;
    for (int k = 0; k < pix_q.size() && k < TOTAL; k++) if (pix_q[k] === rom_mem[k]) good_p++;
    for (int k = 0; k < addr_q.size() && k < TOTAL; k++) if (addr_q[k] == k) good_a++;
    checks++;
    if (good_p != TOTAL || pix_q.size() != TOTAL) begin
      errors++;
      $display("FAIL %s_pixels: got %0d matching of %0d, want %0d", tag, good_p, pix_q.size(), TOTAL);
    end
    checks++;
    if (good_a != TOTAL || addr_q.size() != TOTAL) begin
      errors++;
      $display("FAIL %s_addr_seq: got %0d in order of %0d distinct, want %0d", tag, good_a, addr_q.size(), TOTAL);
    end
    checks++;
    if (run_q.size() != NIMG || run_q[0] != IMG || run_q[NIMG-1] != IMG) begin
      errors++;
      $display("FAIL %s_valid_runs: got %0d runs first %0d, want %0d runs of %0d",
               tag, run_q.size(), (run_q.size() > 0) ? run_q[0] : 0, NIMG, IMG);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus.rom_addr !== '0 || bus.map_valid !== 1'b0 || bus.lenet_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got addr=%0d mv=%b en=%b busy=%b, want 0 0 0 0",
               bus.rom_addr, bus.map_valid, bus.lenet_en, busy);
    end
    checks++;
    if (result_valid !== 1'b0 || result_index !== 4'd0 || result_img !== '0 || done !== 1'b0 || err !== 1'b0 || perf_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_status: got rv=%b ri=%0d img=%0d done=%b err=%b perf=%0d, want all 0",
               result_valid, result_index, result_img, done, err, perf_cycles);
    end
    tick(); rst_n = 1'b1; tick();
    // Reset in the middle of streaming the first image
    pulse_start();
    wait_addr(300);
    checks++;
    if (bus.map_valid !== 1'b1 || bus.lenet_en !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_active: got mv=%b en=%b, want 1 1", bus.map_valid, bus.lenet_en);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rom_addr !== '0 || bus.map_valid !== 1'b0 || bus.lenet_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_ctrl: got addr=%0d mv=%b en=%b busy=%b done=%b, want all 0",
               bus.rom_addr, bus.map_valid, bus.lenet_en, busy, done);
    end
    checks++;
    if (result_valid !== 1'b0 || result_img !== '0 || err !== 1'b0 || perf_cycles !== 32'd0) begin
      errors++;
      $display("FAIL async_reset_status: got rv=%b img=%0d err=%b perf=%0d, want all 0",
               result_valid, result_img, err, perf_cycles);
    end
    tick(); rst_n = 1'b1; repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || bus.rom_addr !== '0) begin
      errors++;
      $display("FAIL reset_stays_idle: got busy=%b addr=%0d, want 0 0", busy, bus.rom_addr);
    end
  endtask

  task automatic test_stream_results();
    clear_mon();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || bus.rom_addr !== '0) begin
      errors++;
      $display("FAIL start_accept: got busy=%b addr=%0d, want 1 0", busy, bus.rom_addr);
    end
    wait_addr(IMG - 1);
    repeat (5) tick();
    pulse_l1();
    checks++;
    if (int'(bus.rom_addr) != IMG) begin
      errors++;
      $display("FAIL next_base: got %0d want %0d", bus.rom_addr, IMG);
    end
    wait_addr(IMG + 200);
    pulse_finish(4'd7);
    checks++;
    if (result_valid !== 1'b1 || result_index !== 4'd7 || result_img !== '0) begin
      errors++;
      $display("FAIL result0: got rv=%b idx=%0d img=%0d, want 1 7 0", result_valid, result_index, result_img);
    end
    wait_addr(TOTAL - 1);
    repeat (3) tick();
    pulse_l1();
    repeat (4) tick();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL drain_waits: got busy=%b done=%b, want 1 0", busy, done);
    end
    pulse_finish(4'd3);
    checks++;
    if (result_valid !== 1'b1 || result_index !== 4'd3 || int'(result_img) != 1 || done !== 1'b0) begin
      errors++;
      $display("FAIL result1: got rv=%b idx=%0d img=%0d done=%b, want 1 3 1 0",
               result_valid, result_index, result_img, done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || bus.lenet_en !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got done=%b en=%b, want 1 0", done, bus.lenet_en);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: got done=%b busy=%b, want 0 0", done, busy);
    end
    check_stream("main");
    checks++;
    if (first_mv < 0 || first_en != first_mv) begin
      errors++;
      $display("FAIL lenet_en_rise: got cycle %0d want %0d", first_en, first_mv);
    end
    checks++;
    if (res_cyc_q.size() != 2 || done_cyc_q.size() != 1 || done_cyc_q[0] != res_cyc_q[1] + 1) begin
      errors++;
      $display("FAIL done_timing: got %0d results %0d dones, want 2 results and done one cycle after the last",
               res_cyc_q.size(), done_cyc_q.size());
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL clean_batch_err: got %b want 0", err);
    end
    // finish while idle flags an error and produces no result
    pulse_finish(4'd5);
    checks++;
    if (err !== 1'b1 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_finish: got err=%b rv=%b, want 1 0", err, result_valid);
    end
  endtask

  task automatic test_protocol_errors();
    logic [3:0] a, b, c;
    a = 4'($urandom); b = 4'($urandom); c = 4'($urandom);
    clear_mon();
    pulse_start();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL start_clears_err: got %b want 0", err);
    end
    wait_addr(100);
    pulse_l1();
    checks++;
    if (err !== 1'b1 || int'(bus.rom_addr) != 101) begin
      errors++;
      $display("FAIL l1_in_stream: got err=%b addr=%0d, want 1 101", err, bus.rom_addr);
    end
    wait_addr(IMG - 1);
    repeat (int'($urandom_range(1, 8))) tick();
    pulse_l1();
    wait_addr(IMG + 100);
    pulse_finish(a);
    repeat (3) tick();
    pulse_finish(b);
    pulse_finish(c);
    checks++;
    if (result_valid !== 1'b0) begin
      errors++;
      $display("FAIL extra_finish_dropped: got rv=%b want 0", result_valid);
    end
    wait_addr(TOTAL - 1);
    repeat (int'($urandom_range(1, 8))) tick();
    pulse_l1();
    wait_done();
    tick();
    check_stream("err");
    checks++;
    if (res_idx_q.size() != 2 || res_idx_q[0] != int'(a) || res_idx_q[1] != int'(b) ||
        res_img_q[0] != 0 || res_img_q[1] != 1) begin
      errors++;
      $display("FAIL err_results: got %0d results, want (0,%0d) (1,%0d)", res_idx_q.size(), a, b);
    end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky: got err=%b busy=%b, want 1 0", err, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] a, b, c, d;
    a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
    clear_mon();
    pulse_start();
    wait_addr(50);
    pulse_start();
    checks++;
    if (int'(bus.rom_addr) != 51) begin
      errors++;
      $display("FAIL start_while_busy: got addr=%0d want 51", bus.rom_addr);
    end
    wait_addr(IMG - 1);
    repeat (int'($urandom_range(1, 8))) tick();
    bus.layer1_finish = 1'b1; bus.finish = 1'b1; bus.index = a;
    tick();
    bus.layer1_finish = 1'b0; bus.finish = 1'b0;
    checks++;
    if (int'(bus.rom_addr) != IMG || result_valid !== 1'b1 || result_index !== a || result_img !== '0) begin
      errors++;
      $display("FAIL same_cycle_l1_finish: got addr=%0d rv=%b idx=%0d img=%0d, want %0d 1 %0d 0",
               bus.rom_addr, result_valid, result_index, result_img, IMG, a);
    end
    wait_addr(TOTAL - 1);
    repeat (int'($urandom_range(1, 8))) tick();
    pulse_l1();
    repeat (int'($urandom_range(0, 6))) tick();
    pulse_finish(b);
    wait_done();
    tick();
    check_stream("b2b");
    // Second batch started the first cycle back in IDLE
    clear_mon();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || bus.rom_addr !== '0 || err !== 1'b0) begin
      errors++;
      $display("FAIL restart: got busy=%b addr=%0d err=%b, want 1 0 0", busy, bus.rom_addr, err);
    end
    drive_batch(int'($urandom_range(1, 10)), int'($urandom_range(1, 10)), c, d);
    tick();
    checks++;
    if (res_idx_q.size() != 2 || res_idx_q[0] != int'(c) || res_idx_q[1] != int'(d) ||
        res_img_q[0] != 0 || res_img_q[1] != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_results: got %0d results busy=%b, want (0,%0d) (1,%0d) busy 0",
               res_idx_q.size(), busy, c, d);
    end
  endtask

  task automatic test_perf();
    clear_mon();
    pulse_start();
    drive_batch(10, int'($urandom_range(1, 12)), 4'($urandom), 4'($urandom));
    tick();
`ifdef LENET_FEEDER_PERF_EN
    checks++;
    if (int'(perf_cycles) != busy_cnt) begin
      errors++;
      $display("FAIL perf_count: got %0d want %0d", perf_cycles, busy_cnt);
    end
    repeat (10) tick();
    checks++;
    if (int'(perf_cycles) != busy_cnt) begin
      errors++;
      $display("FAIL perf_hold: got %0d want %0d", perf_cycles, busy_cnt);
    end
`else
    checks++;
    if (perf_cycles !== 32'd0 || busy_cnt == 0) begin
      errors++;
      $display("FAIL perf_tied: got %0d after %0d busy cycles, want 0", perf_cycles, busy_cnt);
    end
`endif
  endtask

  initial begin
    bus.layer1_finish = 1'b0;
    bus.finish = 1'b0;
    bus.index = 4'd0;
    for (int k = 0; k < TOTAL; k++) rom_mem[k] = 16'($urandom);
    clear_mon();
    test_reset();
    test_stream_results();
    test_protocol_errors();
    test_back_to_back();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
